// File: rtl/tx_arb_pkg.sv
// Shared types and sizing helpers for the tx_frame_arbiter slice.
package tx_arb_pkg;

    typedef enum logic [2:0] {
        HOLD,
        IDLE,
        START,
        SEND,
        GAP
    } state_t;

    function automatic int frame_len(input int signal_duration, input int frame_bits);
        return (signal_duration + 1) * frame_bits;
    endfunction

    // One counter serves both the frame and the gap, so size it for whichever is longer.
    function automatic int cnt_width(input int flen, input int gap);
        int m;
        m = (flen > gap) ? flen : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational one-hot winner selection; round-robin from ptr, or fixed lowest-index
// priority when TX_ARB_FIXED_PRIO_EN is defined (ptr is then ignored).
module tx_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

`ifdef TX_ARB_FIXED_PRIO_EN
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`else
    logic found;
    int   idx;

    // Only the first set bit in search order is ever examined as a winner, so a
    // non-winning index later in the order cannot disturb the result.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/tx_frame_arbiter.sv
// Round-robin sharing of one serial transmitter among NUM_REQ byte sources, with self-timed
// frame spacing. Define TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module tx_frame_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int SIGNAL_DURATION = 1,
    parameter int FRAME_BITS      = 11,
    parameter int GAP_CYCLES      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int FRAME_LEN = frame_len(SIGNAL_DURATION, FRAME_BITS);
    localparam int CW        = cnt_width(FRAME_LEN, GAP_CYCLES);
    localparam int IDW       = $clog2(NUM_REQ);

    localparam logic [CW-1:0]  FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0]  GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDW-1:0] LAST_ID    = IDW'(NUM_REQ - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] win;
    logic [IDW-1:0]     win_id;
    logic [7:0]         win_data;
    logic [IDW-1:0]     ptr;

`ifdef TX_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`endif

    tx_rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (ptr),
        .grant(win)
    );

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_id   = IDW'(i);
                win_data = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD;
            cnt      <= FRAME_LAST;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            busy     <= 1'b1;
`ifndef TX_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (state)
                // The transmitter is not reset with us; let any frame in flight finish.
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (|win) begin
                        ack      <= win;
                        tx_data  <= win_data;
                        grant_id <= win_id;
`ifndef TX_ARB_FIXED_PRIO_EN
                        ptr      <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
`endif
                        state    <= START;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    tx_start <= 1'b1;
                    cnt      <= FRAME_LAST;
                    state    <= SEND;
                end
                SEND: begin
                    if (cnt == '0) begin
                        if (GAP_CYCLES > 0) begin
                            state <= GAP;
                            cnt   <= GAP_LAST;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                    cnt   <= FRAME_LAST;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: a timing/arbitration model predicts grants, a monitor checks.
module tb_tx_frame_arbiter;

    localparam int N  = 4;
    localparam int SD = 1;
    localparam int FB = 11;
    localparam int G  = 3;
    localparam int FL = (SD + 1) * FB;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           busy;

    tx_frame_arbiter #(
        .NUM_REQ(N), .SIGNAL_DURATION(SD), .FRAME_BITS(FB), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_start(tx_start), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         edge_n;
        int         id;
        logic [7:0] data;
    } grant_t;

    grant_t     sb[$];
    grant_t     g;
    int         vectors = 0;
    int         errors  = 0;
    int         cyc = 0;
    int         ptr_m = 0;
    int         next_decide = FL + 1;
    int         start_edge = -1;
    logic [7:0] exp_data = '0;
    int         exp_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: one decision per frame slot, winner = first pending requester at or after ptr.
    always @(posedge clk) begin
        int e;
        int w;
        int idx;
        if (rst) begin
            cyc         <= 0;
            ptr_m       <= 0;
            next_decide <= FL + 1;
            start_edge  <= -1;
            exp_data    <= '0;
            exp_id      <= 0;
            sb.delete();
        end else begin
            e = cyc + 1;
            cyc <= e;
            if (e >= next_decide && req != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (ptr_m + k) % N;
                    if (w < 0 && req[idx]) w = idx;
                end
                sb.push_back('{edge_n: e, id: w, data: req_data[8*w +: 8]});
                ptr_m       <= (w + 1) % N;
                next_decide <= e + FL + G + 2;
                start_edge  <= e + 1;
                exp_data    <= req_data[8*w +: 8];
                exp_id      <= w;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ack", 32'(ack), 0);
            chk("rst_tx_start", 32'(tx_start), 0);
            chk("rst_tx_data", 32'(tx_data), 0);
            chk("rst_grant_id", 32'(grant_id), 0);
            chk("rst_busy", 32'(busy), 1);
        end else begin
            if (ack != '0) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 0);
                end else begin
                    g = sb.pop_front();
                    chk("ack_vec", 32'(ack), 32'(1) << g.id);
                    chk("ack_cycle", cyc, g.edge_n);
                    chk("ack_grant_id", 32'(grant_id), g.id);
                    chk("ack_tx_data", 32'(tx_data), 32'(g.data));
                end
            end else if (sb.size() != 0 && sb[0].edge_n <= cyc) begin
                g = sb.pop_front();
                chk("ack_missing", 32'(ack), 32'(1) << g.id);
            end
            chk("tx_start", 32'(tx_start), 32'(cyc == start_edge));
            chk("busy", 32'(busy), 32'(cyc < next_decide - 1));
            chk("tx_data_hold", 32'(tx_data), 32'(exp_data));
            chk("grant_id_hold", 32'(grant_id), exp_id);
        end
    end

    // Random requesters: after an ack either re-present a new byte or drop; idle ones may raise or withdraw.
    task automatic run(input int ncyc, input int p_raise, input int p_drop);
        repeat (ncyc) begin
            @(negedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(99) < p_raise) req_data[8*i +: 8] = 8'($urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(99) < p_raise) begin
                        req[i] = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(99) < p_drop) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_bound(input string name, input int which_ack);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (which_ack >= 0 && ack[which_ack]) begin
                req[which_ack] = 1'b0;
                seen = 1'b1;
            end else if (which_ack < 0 && tx_start) begin
                seen = 1'b1;
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: event not seen within 200 cycles", name);
        end
    endtask

    initial begin
        // Requester 2 pending through reset and the post-reset hold window.
        req[2] = 1'b1;
        req_data[23:16] = 8'h5D;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        wait_bound("first_ack", 2);
        run(40, 0, 0);

        // All four requesters held continuously: strict rotation, back-to-back frames.
        req = '1;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        run(150, 100, 0);
        req = '0;
        run(40, 0, 0);

        // Request raised and withdrawn while a frame is on the wire.
        req[0] = 1'b1;
        req_data[7:0] = 8'h3C;
        wait_bound("withdraw_setup_ack", 0);
        repeat (3) @(negedge clk);
        #1 req[1] = 1'b1;
        req_data[15:8] = 8'hE1;
        repeat (5) @(negedge clk);
        #1 req[1] = 1'b0;
        run(40, 0, 0);

        // Reset in the middle of a frame must clear outputs at once.
        req[3] = 1'b1;
        req_data[31:24] = 8'hA7;
        wait_bound("mid_frame_ack", 3);
        wait_bound("mid_frame_start", -1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ack", 32'(ack), 0);
        chk("async_tx_start", 32'(tx_start), 0);
        chk("async_tx_data", 32'(tx_data), 0);
        chk("async_busy", 32'(busy), 1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        req[1] = 1'b1;
        req_data[15:8] = 8'h96;
        run(60, 0, 0);

        // Random traffic with withdrawals.
        run(3000, 30, 5);
        req = '0;
        run(80, 0, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
